// File: rtl/shift_reg_ctrl.sv
// Sequencer that serialises a parallel word MSB-first into a serial-in shift register and returns its contents.
// Optional loopback compare of the captured word against the sent word: define LOOPBACK_CHECK_EN.
module shift_reg_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             SI,
    output logic             shift_en,
    input  logic [WIDTH-1:0] A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_buf;
    logic [WIDTH-1:0] r_out_data;
    logic            r_out_valid;
    logic            r_started;
    logic [CW-1:0]   w_idx;
    logic            w_accept;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid may rise without waiting for ready, and ready never depends on valid.
    assign w_idx       = LAST - r_cnt;
    assign w_accept    = (r_state == IDLE) && r_started && in_valid;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign o_dbg_state = r_state;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        shift_en = 1'b0;
        SI       = 1'b0;
        case (r_state)
            IDLE: begin
                // Held low until the first edge after reset release.
                in_ready = r_started;
                if (w_accept) w_next = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                SI       = r_buf[w_idx];
                if (r_cnt == LAST) w_next = CAPTURE;
            end
            CAPTURE: w_next = HOLD;
            HOLD: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_started   <= 1'b0;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_buf <= in_data;
                        r_cnt <= '0;
                    end
                end
                SHIFT: r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                CAPTURE: begin
                    r_out_data  <= A;
                    r_out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: begin
                    r_cnt       <= '0;
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOOPBACK_CHECK_EN
    logic r_err;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_err <= 1'b0;
        end else if (r_state == CAPTURE) begin
            r_err <= (A != r_buf);
        end else if ((r_state == HOLD && out_ready) || r_state == IDLE) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: drives words, models the external shift register, checks against a word-level reference.
module tb_shift_reg_ctrl;

  localparam int W = 6;

  // clock/reset block
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, si, shift_en, out_valid, out_ready, err;
  logic [W-1:0] in_data, a, out_data;
  logic [1:0]   dbg_state;

  shift_reg_ctrl #(.WIDTH(W)) dut (
    .Clock      (clk),
    .Resetn     (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .SI         (si),
    .shift_en   (shift_en),
    .A          (a),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err        (err),
    .o_dbg_state(dbg_state)
  );

  // External shift register; stuck_mask forces selected A bits to 0.
  logic [W-1:0] sr = '0;
  logic [W-1:0] stuck_mask = '0;
  always @(posedge clk) if (shift_en === 1'b1) sr <= {sr[W-2:0], si};
  assign a = sr & ~stuck_mask;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word the consumer should see: sent word seen through the (possibly faulty) register.
  function automatic logic [W-1:0] expected_out(input logic [W-1:0] w);
    return w & ~stuck_mask;
  endfunction

  function automatic logic expected_err(input logic [W-1:0] w);
`ifdef LOOPBACK_CHECK_EN
    return (expected_out(w) != w);
`else
    return 1'b0;
`endif
  endfunction

  // driver: one full word transaction, entered and left on a falling edge
  task automatic send_word(input logic [W-1:0] w, input int bp, input bit busy);
    logic [W-1:0] e;
    logic         e_err;
    int           k;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = w;
    exp_q.push_back(expected_out(w));
    e_err = expected_err(w);
    @(posedge clk);
    #1;
    if (busy) begin
      in_data   = '1;
      out_ready = 1'b1;
    end else begin
      in_valid = 1'b0;
      in_data  = W'($urandom_range(0, (1 << W) - 1));
    end
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("shift_en_high", shift_en, 1);
      check("si_bit", si, (w >> (W - 1 - i)) & 1);
      check("ready_low_shift", in_ready, 0);
      check("valid_low_shift", out_valid, 0);
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("capture_shift_en", shift_en, 0);
    check("capture_valid", out_valid, 0);
    @(negedge clk);
    e = exp_q.pop_front();
    check("out_valid_rise", out_valid, 1);
    check("out_data", out_data, e);
    check("err", err, e_err);
    check("ready_low_hold", in_ready, 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, e);
      check("bp_shift_en", shift_en, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", out_valid, 0);
    check("ready_idle", in_ready, 1);
    check("err_clear", err, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // 1: reset values and release
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_shift_en", shift_en, 0);
    check("rst_si", si, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("ready_after_edge", in_ready, 1);

    // 2: basic
    send_word(6'b101101, 0, 1'b0);
    // 3: backpressure
    send_word(6'b010011, 5, 1'b0);
    // 4: busy ignore, then the all-ones word proper
    send_word(6'b100110, 2, 1'b1);
    send_word(6'b111111, 0, 1'b0);

    // 5: reset after 3 shifts
    in_valid = 1'b1;
    in_data  = 6'b110011;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_shift_en", shift_en, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_shift_en", shift_en, 0);
    check("midrst_si", si, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
    end
    send_word(6'b000111, 0, 1'b0);

    // randomized words with random backpressure and gaps
    for (int n = 0; n < 16; n++) begin
      send_word(W'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef LOOPBACK_CHECK_EN
    // 6: stuck-at-0 on A[2]
    stuck_mask = 6'b000100;
    send_word(6'b000100, 1, 1'b0);
    send_word(6'b000000, 0, 1'b0);
    stuck_mask = '0;
`else
    send_word(6'b000100, 1, 1'b0);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
